// File: rtl/bram_sample_streamer.sv
// Streams NUM_SAMPLES words from a one-cycle-latency ROM as a valid/ready stream,
// single pass or looping, through a 2-entry skid FIFO that absorbs the read latency.
module bram_sample_streamer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 101,
  parameter int unsigned LEN         = $clog2(DEPTH),
  parameter int unsigned NUM_SAMPLES = 8,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic             i_strm_clk,
  input  logic             i_strm_rst,
  input  logic             i_strm_start,
  input  logic             i_strm_stop,
  input  logic             i_strm_loop,
  output logic             o_strm_bram_rden,
  output logic [LEN-1:0]   o_strm_bram_addr,
  input  logic [WIDTH-1:0] i_strm_bram_data,
  output logic [WIDTH-1:0] o_strm_data,
  output logic             o_strm_valid,
  input  logic             i_strm_ready,
  output logic             o_strm_busy,
  output logic             o_strm_done
);

  localparam int unsigned    CW       = $clog2(NUM_SAMPLES + 1);
  localparam logic [CW-1:0]  NumCnt   = CW'(NUM_SAMPLES);
  localparam logic [CW-1:0]  LastAcc  = CW'(NUM_SAMPLES - 1);
  localparam logic [LEN-1:0] BaseAddr = LEN'(BASE_ADDR);
  localparam logic [LEN-1:0] LastAddr = LEN'(BASE_ADDR + NUM_SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e           state_q;
  logic             loop_q;
  logic             inflight_q;
  logic             done_q;
  logic [CW-1:0]    issue_cnt_q;
  logic [CW-1:0]    accept_cnt_q;
  logic [LEN-1:0]   addr_q;
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;

  logic pop;
  logic rden;

  // Only issue a read if the word will have a FIFO slot when it returns.
  always_comb begin
    pop  = (occ_q != 2'd0) && i_strm_ready;
    rden = (state_q == StStream) && (loop_q || (issue_cnt_q < NumCnt)) &&
           (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
  end

  always_ff @(posedge i_strm_clk) begin
    if (i_strm_rst) begin
      state_q      <= StIdle;
      loop_q       <= 1'b0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      addr_q       <= BaseAddr;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rden;
      if (rden) begin
        addr_q <= (addr_q == LastAddr) ? BaseAddr : addr_q + 1'b1;
        if (!loop_q) issue_cnt_q <= issue_cnt_q + 1'b1;
      end
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= i_strm_bram_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (!loop_q) accept_cnt_q <= accept_cnt_q + 1'b1;
      end
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};

      unique case (state_q)
        StIdle: begin
          if (i_strm_start) begin
            state_q      <= StStream;
            loop_q       <= i_strm_loop;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            addr_q       <= BaseAddr;
          end
        end
        StStream, StDrain: begin
          // Stop overrides everything: flush buffered data and drop the returning word.
          if (i_strm_stop) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
          end else if (state_q == StStream) begin
            if (!loop_q && (issue_cnt_q == NumCnt)) state_q <= StDrain;
          end else if (pop && (accept_cnt_q == LastAcc)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_strm_bram_rden = rden;
  assign o_strm_bram_addr = addr_q;
  assign o_strm_valid     = (occ_q != 2'd0);
  assign o_strm_data      = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign o_strm_busy      = (state_q != StIdle);
  assign o_strm_done      = done_q;

endmodule

// File: tb/tb_bram_sample_streamer.sv
// Directed bench: ROM holds addr+1 at each address; checks latency, ordering,
// backpressure, looping, stop, reset and a single-word pass at a non-zero base.
module tb_bram_sample_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] rom [0:100];

  // Instance A: 8 words from address 0
  logic        a_start = 0, a_stop = 0, a_loop = 0, a_ready = 1;
  logic        a_rden, a_valid, a_busy, a_done;
  logic [6:0]  a_addr;
  logic [15:0] a_bram_data = '0, a_data;

  // Instance B: 1 word from address 5
  logic        b_start = 0, b_stop = 0, b_loop = 0, b_ready = 0;
  logic        b_rden, b_valid, b_busy, b_done;
  logic [6:0]  b_addr;
  logic [15:0] b_bram_data = '0, b_data;

  bram_sample_streamer #(.WIDTH(16), .DEPTH(101), .NUM_SAMPLES(8), .BASE_ADDR(0)) dut_a (
    .i_strm_clk(clk), .i_strm_rst(rst), .i_strm_start(a_start), .i_strm_stop(a_stop),
    .i_strm_loop(a_loop), .o_strm_bram_rden(a_rden), .o_strm_bram_addr(a_addr),
    .i_strm_bram_data(a_bram_data), .o_strm_data(a_data), .o_strm_valid(a_valid),
    .i_strm_ready(a_ready), .o_strm_busy(a_busy), .o_strm_done(a_done)
  );

  bram_sample_streamer #(.WIDTH(16), .DEPTH(101), .NUM_SAMPLES(1), .BASE_ADDR(5)) dut_b (
    .i_strm_clk(clk), .i_strm_rst(rst), .i_strm_start(b_start), .i_strm_stop(b_stop),
    .i_strm_loop(b_loop), .o_strm_bram_rden(b_rden), .o_strm_bram_addr(b_addr),
    .i_strm_bram_data(b_bram_data), .o_strm_data(b_data), .o_strm_valid(b_valid),
    .i_strm_ready(b_ready), .o_strm_busy(b_busy), .o_strm_done(b_done)
  );

  always @(posedge clk) begin
    if (a_rden) a_bram_data <= rom[a_addr];
    if (b_rden) b_bram_data <= rom[b_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (a_busy && n < bound) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, a_busy}, 0);
  endtask

  // Stream monitor for A, sampled mid-cycle so inputs and outputs are settled.
  logic [15:0] got[$];
  logic [6:0]  addrq[$];
  int          rden_cnt = 0;
  int          done_cnt = 0;
  logic        a_stall_prev = 1'b0;
  logic [15:0] a_data_prev = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("occ_le_2", {31'd0, (dut_a.occ_q <= 2'd2)}, 1);
      if (a_stall_prev) begin
        chk("stall_valid", {31'd0, a_valid}, 1);
        chk("stall_data", {16'd0, a_data}, {16'd0, a_data_prev});
      end
      if (a_valid && a_ready) got.push_back(a_data);
      if (a_rden) begin
        rden_cnt++;
        addrq.push_back(a_addr);
      end
      if (a_done) done_cnt++;
    end
    a_stall_prev = a_valid && !a_ready && !a_stop && !rst;
    a_data_prev  = a_data;
  end

  initial begin
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    for (int i = 0; i <= 100; i++) rom[i] = 16'(i + 1);

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_rden", {31'd0, a_rden}, 0);
    chk("rst_addr", {25'd0, a_addr}, 0);
    chk("rst_valid", {31'd0, a_valid}, 0);
    chk("rst_data", {16'd0, a_data}, 0);
    chk("rst_busy", {31'd0, a_busy}, 0);
    chk("rst_done", {31'd0, a_done}, 0);
    chk("rst_b_addr", {25'd0, b_addr}, 5);
    rst = 1'b0;
    step();

    // Single pass, full throughput
    got.delete(); rden_cnt = 0; done_cnt = 0;
    a_loop = 0; a_ready = 1; a_start = 1;
    step();
    a_start = 0;
    chk("t1_busy", {31'd0, a_busy}, 1);
    chk("t1_rden", {31'd0, a_rden}, 1);
    chk("t1_valid_e0", {31'd0, a_valid}, 0);
    step();
    chk("t1_valid_e1", {31'd0, a_valid}, 0);
    step();
    chk("t1_valid_e2", {31'd0, a_valid}, 1);
    chk("t1_first_data", {16'd0, a_data}, 1);
    wait_idle(40);
    chk("t1_done_high", {31'd0, a_done}, 1);
    step();
    chk("t1_done_low", {31'd0, a_done}, 0);
    chk("t1_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_data", {16'd0, got[i]}, i + 1);
    chk("t1_rden_cnt", rden_cnt, 8);
    chk("t1_done_cnt", done_cnt, 1);

    // Backpressure with ready pattern 1,0,0,1
    got.delete(); rden_cnt = 0; done_cnt = 0;
    a_start = 1;
    step();
    a_start = 0;
    n = 0;
    while (a_busy && n < 80) begin
      a_ready = pat[n % 4];
      step();
      n++;
    end
    chk("t2_idle", {31'd0, a_busy}, 0);
    chk("t2_done_high", {31'd0, a_done}, 1);
    a_ready = 1;
    step();
    chk("t2_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_data", {16'd0, got[i]}, i + 1);
    chk("t2_rden_cnt", rden_cnt, 8);
    chk("t2_done_cnt", done_cnt, 1);

    // Loop mode: 20 samples then stop
    got.delete(); addrq.delete(); done_cnt = 0;
    a_loop = 1; a_start = 1;
    step();
    a_start = 0;
    n = 0;
    while (got.size() < 20 && n < 40) begin
      step();
      n++;
    end
    a_stop = 1;
    step();
    a_stop = 0;
    a_loop = 0;
    chk("t3_valid_after_stop", {31'd0, a_valid}, 0);
    chk("t3_busy_after_stop", {31'd0, a_busy}, 0);
    chk("t3_count", {31'd0, got.size() >= 20}, 1);
    for (int i = 0; i < 20; i++) chk("t3_data", {16'd0, got[i]}, (i % 8) + 1);
    chk("t3_addr7", {25'd0, addrq[7]}, 7);
    chk("t3_addr_wrap", {25'd0, addrq[8]}, 0);
    chk("t3_no_done", done_cnt, 0);

    // Stop the cycle after the 3rd handshake, then restart
    got.delete(); done_cnt = 0;
    a_start = 1;
    step();
    a_start = 0;
    n = 0;
    while (got.size() < 3 && n < 20) begin
      step();
      n++;
    end
    a_stop = 1;
    step();
    a_stop = 0;
    chk("t4_valid", {31'd0, a_valid}, 0);
    chk("t4_busy", {31'd0, a_busy}, 0);
    chk("t4_done", {31'd0, a_done}, 0);
    step(); step(); step();
    chk("t4_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_data", {16'd0, got[i]}, i + 1);
    chk("t4_valid_later", {31'd0, a_valid}, 0);
    chk("t4_no_done", done_cnt, 0);
    got.delete();
    a_start = 1;
    step();
    a_start = 0;
    wait_idle(40);
    chk("t4_restart_done", {31'd0, a_done}, 1);
    step();
    chk("t4_restart_count", got.size(), 8);
    chk("t4_restart_first", {16'd0, got[0]}, 1);
    chk("t4_restart_last", {16'd0, got[7]}, 8);

    // Reset mid-pass with the FIFO full
    done_cnt = 0;
    a_ready = 0; a_start = 1;
    step();
    a_start = 0;
    repeat (4) step();
    chk("t5_valid_pre", {31'd0, a_valid}, 1);
    chk("t5_rden_pre", {31'd0, a_rden}, 0);
    chk("t5_occ_pre", {30'd0, dut_a.occ_q}, 2);
    chk("t5_addr_pre", {25'd0, a_addr}, 2);
    rst = 1;
    step();
    chk("t5_rden", {31'd0, a_rden}, 0);
    chk("t5_addr", {25'd0, a_addr}, 0);
    chk("t5_valid", {31'd0, a_valid}, 0);
    chk("t5_data", {16'd0, a_data}, 0);
    chk("t5_busy", {31'd0, a_busy}, 0);
    chk("t5_done", {31'd0, a_done}, 0);
    rst = 0;
    a_ready = 1;
    step();
    chk("t5_done_after", {31'd0, a_done}, 0);
    chk("t5_valid_after", {31'd0, a_valid}, 0);
    chk("t5_no_done", done_cnt, 0);

    // Single-word pass from address 5 under backpressure
    b_ready = 0; b_start = 1;
    step();
    b_start = 0;
    chk("t6_rden", {31'd0, b_rden}, 1);
    chk("t6_addr", {25'd0, b_addr}, 5);
    step();
    chk("t6_rden_once", {31'd0, b_rden}, 0);
    chk("t6_valid_e1", {31'd0, b_valid}, 0);
    step();
    chk("t6_valid", {31'd0, b_valid}, 1);
    chk("t6_data", {16'd0, b_data}, 6);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_hold_valid", {31'd0, b_valid}, 1);
      chk("t6_hold_data", {16'd0, b_data}, 6);
      chk("t6_hold_rden", {31'd0, b_rden}, 0);
    end
    b_ready = 1;
    step();
    chk("t6_busy", {31'd0, b_busy}, 0);
    chk("t6_done_high", {31'd0, b_done}, 1);
    chk("t6_valid_after", {31'd0, b_valid}, 0);
    step();
    chk("t6_done_low", {31'd0, b_done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
